// File: rtl/wt_cache_pkg.sv
// Shared types and widths for the write-through dcache load request path.
package wt_cache_pkg;

  localparam int unsigned DCACHE_INDEX_WIDTH = 12;
  localparam int unsigned DCACHE_TAG_WIDTH   = 22;
  localparam int unsigned DCACHE_TID_WIDTH   = 2;
  localparam int unsigned LD_LAT_WIDTH       = 8;

  // Load request sequencer states: one outstanding load at a time.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    TAG,
    WAIT,
    KILL
  } ld_state_e;

  // Access size encoding as presented by the load unit.
  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_HALF  = 2'b01,
    SIZE_WORD  = 2'b10,
    SIZE_DWORD = 2'b11
  } ld_size_e;

endpackage

// File: rtl/wt_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
module wt_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  // Clear wins over enable; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wt_dcache_ld_req.sv
// Load request sequencer between the load unit and a write-through dcache:
// issues the index phase, forwards the translated tag (or kills the access),
// and returns data plus the grant-to-data latency to the load unit.
module wt_dcache_ld_req
  import wt_cache_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned IDX_W = DCACHE_INDEX_WIDTH,
  parameter int unsigned TAG_W = DCACHE_TAG_WIDTH,
  parameter int unsigned TID_W = DCACHE_TID_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // load unit request
  input  logic                    ld_valid_i,
  output logic                    ld_ready_o,
  input  logic [IDX_W-1:0]        ld_index_i,
  input  logic [1:0]              ld_size_i,
  input  logic [TID_W-1:0]        ld_id_i,
  // translation result
  input  logic                    tlb_valid_i,
  input  logic [TAG_W-1:0]        tlb_tag_i,
  input  logic                    tlb_exc_i,
  input  logic                    flush_i,
  // dcache request phase
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [IDX_W-1:0]        address_index_o,
  output logic [1:0]              data_size_o,
  output logic [TID_W-1:0]        data_id_o,
  output logic                    data_we_o,
  // dcache tag / kill phase
  output logic [TAG_W-1:0]        address_tag_o,
  output logic                    tag_valid_o,
  output logic                    kill_req_o,
  // dcache response
  input  logic                    data_rvalid_i,
  input  logic [XLEN-1:0]         data_rdata_i,
  input  logic [TID_W-1:0]        data_rid_i,
  // response to load unit
  output logic                    resp_valid_o,
  output logic [XLEN-1:0]         resp_data_o,
  output logic [TID_W-1:0]        resp_id_o,
  output logic                    resp_exc_o,
  output logic [LD_LAT_WIDTH-1:0] resp_lat_o
);

  ld_state_e         state_q, state_d;
  logic [IDX_W-1:0]  index_q;
  ld_size_e          size_q;
  logic [TID_W-1:0]  id_q;
  logic [TAG_W-1:0]  tag_q;
  logic              kill_exc_q;   // current kill came from a translation fault
  logic              rid_err_q;    // sticky: response id did not match the request
  logic              resp_valid_q;
  logic [XLEN-1:0]   resp_data_q;
  logic [TID_W-1:0]  resp_id_q;
  logic              resp_exc_q;
  logic              rsp_accept;

  // A response is only meaningful once the tag phase has been resolved.
  assign rsp_accept = data_rvalid_i && ((state_q == WAIT) || (state_q == KILL));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush beats grant in REQ, data beats flush in WAIT.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ld_valid_i) state_d = REQ;
      REQ: begin
        if (flush_i)         state_d = IDLE;
        else if (data_gnt_i) state_d = TAG;
      end
      TAG: begin
        if (flush_i)          state_d = KILL;
        else if (tlb_valid_i) state_d = tlb_exc_i ? KILL : WAIT;
      end
      WAIT: begin
        if (data_rvalid_i) state_d = IDLE;
        else if (flush_i)  state_d = KILL;
      end
      KILL: if (data_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and phase strobes decoded from the current state.
  always_comb begin
    ld_ready_o  = 1'b0;
    data_req_o  = 1'b0;
    tag_valid_o = 1'b0;
    kill_req_o  = 1'b0;
    unique case (state_q)
      IDLE:    ld_ready_o  = 1'b1;
      REQ:     data_req_o  = 1'b1;
      WAIT:    tag_valid_o = 1'b1;
      KILL:    kill_req_o  = 1'b1;
      default: ;
    endcase
  end

  // Capture request fields, the translated tag, kill cause and the response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      index_q      <= '0;
      size_q       <= SIZE_BYTE;
      id_q         <= '0;
      tag_q        <= '0;
      kill_exc_q   <= 1'b0;
      rid_err_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_exc_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;

      if ((state_q == IDLE) && ld_valid_i) begin
        index_q <= ld_index_i;
        size_q  <= ld_size_e'(ld_size_i);
        id_q    <= ld_id_i;
      end

      if ((state_q == TAG) && tlb_valid_i && !tlb_exc_i && !flush_i) begin
        tag_q <= tlb_tag_i;
      end

      // A flush overrides a pending fault kill: the load unit no longer wants an answer.
      if ((state_q == TAG) && tlb_valid_i && tlb_exc_i && !flush_i) begin
        kill_exc_q <= 1'b1;
      end else if (flush_i || (state_q == IDLE)) begin
        kill_exc_q <= 1'b0;
      end

      if (rsp_accept && (data_rid_i != id_q)) begin
        rid_err_q <= 1'b1;
      end

      if (data_rvalid_i && (state_q == WAIT)) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= data_rdata_i;
        resp_id_q    <= id_q;
        resp_exc_q   <= 1'b0;
      end else if (data_rvalid_i && (state_q == KILL) && kill_exc_q) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= '0;
        resp_id_q    <= id_q;
        resp_exc_q   <= 1'b1;
      end
    end
  end

  // Grant-to-data latency: restarts on grant, counts through tag/wait/kill.
  wt_sat_cnt #(
    .W (LD_LAT_WIDTH)
  ) i_lat_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i ((state_q == REQ) && data_gnt_i && !flush_i),
    .en_i  ((state_q == TAG) || (state_q == WAIT) || (state_q == KILL)),
    .cnt_o (resp_lat_o)
  );

  assign address_index_o = index_q;
  assign data_size_o     = size_q;
  assign data_id_o       = id_q;
  assign data_we_o       = 1'b0;
  assign address_tag_o   = tag_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = resp_data_q;
  assign resp_id_o       = resp_id_q;
  assign resp_exc_o      = resp_exc_q;

  // Responses must only arrive after the tag phase; ids must match the request.
  a_rvalid_phase : assert property (@(posedge clk_i) disable iff (rst_i)
    data_rvalid_i |-> ((state_q == WAIT) || (state_q == KILL)));
  a_rid_match : assert property (@(posedge clk_i) disable iff (rst_i) !rid_err_q);

endmodule

// File: tb/tb_wt_dcache_ld_req.sv
// Directed bench for wt_dcache_ld_req: hit, delayed grant, TLB fault,
// flushes, latency saturation and mid-operation reset.
module tb_wt_dcache_ld_req;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [11:0] ld_index_i;
  logic [1:0]  ld_size_i;
  logic [1:0]  ld_id_i;
  logic        tlb_valid_i;
  logic [21:0] tlb_tag_i;
  logic        tlb_exc_i;
  logic        flush_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic [11:0] address_index_o;
  logic [1:0]  data_size_o;
  logic [1:0]  data_id_o;
  logic        data_we_o;
  logic [21:0] address_tag_o;
  logic        tag_valid_o;
  logic        kill_req_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic [1:0]  data_rid_i;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic [1:0]  resp_id_o;
  logic        resp_exc_o;
  logic [7:0]  resp_lat_o;

  int n_vec = 0;
  int n_err = 0;

  wt_dcache_ld_req dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .ld_valid_i      (ld_valid_i),
    .ld_ready_o      (ld_ready_o),
    .ld_index_i      (ld_index_i),
    .ld_size_i       (ld_size_i),
    .ld_id_i         (ld_id_i),
    .tlb_valid_i     (tlb_valid_i),
    .tlb_tag_i       (tlb_tag_i),
    .tlb_exc_i       (tlb_exc_i),
    .flush_i         (flush_i),
    .data_req_o      (data_req_o),
    .data_gnt_i      (data_gnt_i),
    .address_index_o (address_index_o),
    .data_size_o     (data_size_o),
    .data_id_o       (data_id_o),
    .data_we_o       (data_we_o),
    .address_tag_o   (address_tag_o),
    .tag_valid_o     (tag_valid_o),
    .kill_req_o      (kill_req_o),
    .data_rvalid_i   (data_rvalid_i),
    .data_rdata_i    (data_rdata_i),
    .data_rid_i      (data_rid_i),
    .resp_valid_o    (resp_valid_o),
    .resp_data_o     (resp_data_o),
    .resp_id_o       (resp_id_o),
    .resp_exc_o      (resp_exc_o),
    .resp_lat_o      (resp_lat_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to 1 time unit after the next rising edge; inputs change and
  // outputs are sampled there, well clear of the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // IDLE -> REQ: present one load for a single cycle.
  task automatic issue(input logic [11:0] idx, input logic [1:0] sz, input logic [1:0] id);
    ld_valid_i = 1'b1;
    ld_index_i = idx;
    ld_size_i  = sz;
    ld_id_i    = id;
    tick();
    ld_valid_i = 1'b0;
  endtask

  // REQ -> TAG -> WAIT with an immediate grant and a clean translation.
  task automatic grant_and_tag(input logic [21:0] tag);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i  = 1'b0;
    tlb_valid_i = 1'b1;
    tlb_tag_i   = tag;
    tick();
    tlb_valid_i = 1'b0;
  endtask

  initial begin
    rst_i         = 1'b1;
    ld_valid_i    = 1'b0;
    ld_index_i    = '0;
    ld_size_i     = '0;
    ld_id_i       = '0;
    tlb_valid_i   = 1'b0;
    tlb_tag_i     = '0;
    tlb_exc_i     = 1'b0;
    flush_i       = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = '0;
    data_rid_i    = '0;

    // ---- reset state
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_ready",    ld_ready_o,      1);
    check("rst_req",      data_req_o,      0);
    check("rst_tagv",     tag_valid_o,     0);
    check("rst_kill",     kill_req_o,      0);
    check("rst_rvalid",   resp_valid_o,    0);
    check("rst_rexc",     resp_exc_o,      0);
    check("rst_index",    address_index_o, 0);
    check("rst_lat",      resp_lat_o,      0);
    check("rst_we",       data_we_o,       0);

    // ---- hit: gnt in the REQ cycle, tag one cycle later, data 3 cycles after gnt
    issue(12'h040, 2'b10, 2'd1);
    check("hit_req",      data_req_o,      1);
    check("hit_ready",    ld_ready_o,      0);
    check("hit_index",    address_index_o, 12'h040);
    check("hit_size",     data_size_o,     2'b10);
    check("hit_id",       data_id_o,       2'd1);
    data_gnt_i = 1'b1;
    tick();                                // TAG
    data_gnt_i = 1'b0;
    check("hit_tag_wait", tag_valid_o,     0);
    tick();                                // still TAG
    tlb_valid_i = 1'b1;
    tlb_tag_i   = 22'h1;
    tick();                                // WAIT
    tlb_valid_i = 1'b0;
    check("hit_tagv",     tag_valid_o,     1);
    check("hit_atag",     address_tag_o,   22'h1);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hDEADBEEF;
    data_rid_i    = 2'd1;
    tick();                                // IDLE, response out
    data_rvalid_i = 1'b0;
    check("hit_rvalid",   resp_valid_o,    1);
    check("hit_rdata",    resp_data_o,     32'hDEADBEEF);
    check("hit_rid",      resp_id_o,       2'd1);
    check("hit_rexc",     resp_exc_o,      0);
    check("hit_lat",      resp_lat_o,      3);
    check("hit_ready2",   ld_ready_o,      1);
    tick();
    check("hit_pulse",    resp_valid_o,    0);

    // ---- delayed grant: request and index stay put while the input wanders
    issue(12'h7FC, 2'b11, 2'd2);
    ld_index_i = 12'h123;
    for (int i = 0; i < 5; i++) begin
      check("dly_req",    data_req_o,      1);
      check("dly_index",  address_index_o, 12'h7FC);
      tick();
    end
    check("dly_size",     data_size_o,     2'b11);
    grant_and_tag(22'h2AAAAA);
    check("dly_atag",     address_tag_o,   22'h2AAAAA);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h12345678;
    data_rid_i    = 2'd2;
    tick();
    data_rvalid_i = 1'b0;
    check("dly_rvalid",   resp_valid_o,    1);
    check("dly_rdata",    resp_data_o,     32'h12345678);
    check("dly_rid",      resp_id_o,       2'd2);
    check("dly_lat",      resp_lat_o,      2);

    // ---- TLB fault: kill held until data returns, then exception response
    issue(12'h100, 2'b00, 2'd3);
    data_gnt_i = 1'b1;
    tick();                                // TAG
    data_gnt_i  = 1'b0;
    tlb_valid_i = 1'b1;
    tlb_exc_i   = 1'b1;
    tlb_tag_i   = 22'h3FFFFF;
    tick();                                // KILL
    tlb_valid_i = 1'b0;
    tlb_exc_i   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("exc_kill",   kill_req_o,      1);
      check("exc_tagv",   tag_valid_o,     0);
      check("exc_norsp",  resp_valid_o,    0);
      if (i == 3) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'hCAFEF00D;
        data_rid_i    = 2'd3;
      end
      tick();
    end
    data_rvalid_i = 1'b0;
    check("exc_rvalid",   resp_valid_o,    1);
    check("exc_rexc",     resp_exc_o,      1);
    check("exc_rdata",    resp_data_o,     0);
    check("exc_rid",      resp_id_o,       2'd3);
    check("exc_lat",      resp_lat_o,      5);
    check("exc_kill_end", kill_req_o,      0);

    // ---- flush in REQ, with a coincident grant: abandoned, no response
    issue(12'h200, 2'b01, 2'd0);
    flush_i    = 1'b1;
    data_gnt_i = 1'b1;
    tick();
    flush_i    = 1'b0;
    data_gnt_i = 1'b0;
    check("frq_req",      data_req_o,      0);
    check("frq_ready",    ld_ready_o,      1);
    check("frq_norsp",    resp_valid_o,    0);
    check("frq_kill",     kill_req_o,      0);
    tick();
    check("frq_norsp2",   resp_valid_o,    0);

    // ---- flush in WAIT: kill with no response once data returns
    issue(12'h010, 2'b10, 2'd2);
    grant_and_tag(22'h15);
    flush_i = 1'b1;
    tick();                                // KILL
    flush_i = 1'b0;
    check("fwt_kill",     kill_req_o,      1);
    check("fwt_tagv",     tag_valid_o,     0);
    data_rvalid_i = 1'b1;
    data_rid_i    = 2'd2;
    data_rdata_i  = 32'h55555555;
    tick();
    data_rvalid_i = 1'b0;
    check("fwt_norsp",    resp_valid_o,    0);
    check("fwt_ready",    ld_ready_o,      1);

    // ---- long miss with flush landing on the data cycle: data wins, latency saturates
    issue(12'h3C0, 2'b10, 2'd0);
    grant_and_tag(22'h0ABCDE);
    for (int i = 0; i < 300; i++) tick();
    check("miss_tagv",    tag_valid_o,     1);
    data_rvalid_i = 1'b1;
    flush_i       = 1'b1;
    data_rdata_i  = 32'h0BADF00D;
    data_rid_i    = 2'd0;
    tick();
    data_rvalid_i = 1'b0;
    flush_i       = 1'b0;
    check("miss_rvalid",  resp_valid_o,    1);
    check("miss_rdata",   resp_data_o,     32'h0BADF00D);
    check("miss_rexc",    resp_exc_o,      0);
    check("miss_lat",     resp_lat_o,      255);
    check("miss_kill",    kill_req_o,      0);
    check("miss_ready",   ld_ready_o,      1);

    // ---- reset while waiting for data, then a clean load
    issue(12'h0F0, 2'b10, 2'd1);
    grant_and_tag(22'h3);
    check("mrst_pre",     tag_valid_o,     1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mrst_tagv",    tag_valid_o,     0);
    check("mrst_req",     data_req_o,      0);
    check("mrst_kill",    kill_req_o,      0);
    check("mrst_rvalid",  resp_valid_o,    0);
    check("mrst_ready",   ld_ready_o,      1);
    check("mrst_index",   address_index_o, 0);
    check("mrst_atag",    address_tag_o,   0);
    check("mrst_lat",     resp_lat_o,      0);
    issue(12'h0AB, 2'b01, 2'd2);
    check("post_index",   address_index_o, 12'h0AB);
    grant_and_tag(22'h7);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hA5A5_0001;
    data_rid_i    = 2'd2;
    tick();
    data_rvalid_i = 1'b0;
    check("post_rvalid",  resp_valid_o,    1);
    check("post_rdata",   resp_data_o,     32'hA5A5_0001);
    check("post_rid",     resp_id_o,       2'd2);
    check("post_lat",     resp_lat_o,      2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
